button_event_arbiter: RTL and testbench

- Front end for all game pushbuttons (up, down, left, right, select).
- Each raw button gets its own synchronizer and debounce counter.
- Debounced press edges are latched as pending events, and a round-robin arbiter offers them one at a time over a valid/ready handshake.
- Sits between the board pins and the game FSM; replaces per-button debounce instances plus ad-hoc edge logic.

---
 rtl/button_event_arbiter.sv | 171 +++++++++++++++++
 tb/tb_button_event_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Pushbutton front end: per-button sync + debounce, press-edge pending latches and a
// round-robin valid/ready event arbiter. Optional auto-repeat under `AUTO_REPEAT_EN.
module button_event_arbiter #(
    parameter int unsigned N_BTN   = 5,
    parameter int unsigned IDW     = 3,
    parameter int unsigned CNT_W   = 16,
    parameter logic [23:0] RPT_DLY = 24'd5000000,
    parameter logic [23:0] RPT_PER = 24'd2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ready,
    output logic             ovf
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StOffer = 1'b1;

    if ((1 << IDW) < N_BTN) begin : g_bad_idw
        $error("IDW too narrow for N_BTN");
    end
    if (RPT_PER == 24'd0 || RPT_PER > RPT_DLY) begin : g_bad_rpt
        $error("RPT_PER must be in 1..RPT_DLY");
    end

    logic [N_BTN-1:0] s0_q, s1_q;
    logic [N_BTN-1:0] state_q, state_d;
    logic [N_BTN-1:0] dly_q;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [IDW-1:0]   rr_q, rr_d, id_q, id_d, pick;
    logic [0:0]       fsm_q, fsm_d;
    logic             valid_q, valid_d, ovf_q, ovf_d, found;
    logic [N_BTN-1:0] press, rpt_set, set, clr;

    // Debounce: a mismatch must persist for 2^CNT_W consecutive edges to flip the state.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (state_q[i] != s1_q[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                if (&cnt_q[i]) state_d[i] = ~state_q[i];
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [23:0] rpt_q [N_BTN];
    logic [23:0] rpt_d [N_BTN];

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            rpt_set[i] = 1'b0;
            rpt_d[i]   = '0;
            if (state_q[i]) begin
                if (rpt_q[i] == RPT_DLY - 24'd1) begin
                    rpt_set[i] = 1'b1;
                    rpt_d[i]   = RPT_DLY - RPT_PER;
                end else begin
                    rpt_d[i] = rpt_q[i] + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rpt_q <= '{default: '0};
        else     rpt_q <= rpt_d;
    end
`else
    assign rpt_set = '0;
`endif

    assign press = state_q & ~dly_q;
    assign set   = press | rpt_set;

    // A set coinciding with the clearing handshake re-arms the bit without flagging overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < N_BTN; i++) begin
            clr[i] = valid_q & evt_ready & (id_q == IDW'(i));
            if (set[i]) begin
                if (pend_q[i] & ~clr[i]) ovf_d = 1'b1;
                pend_d[i] = 1'b1;
            end else if (clr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // First pending index at or above rr_q, wrapping at N_BTN-1.
    always_comb begin
        int sum;
        found = 1'b0;
        pick  = '0;
        sum   = 0;
        for (int k = 0; k < N_BTN; k++) begin
            sum = int'(rr_q) + k;
            if (sum >= int'(N_BTN)) sum = sum - int'(N_BTN);
            if (!found && pend_q[IDW'(sum)]) begin
                found = 1'b1;
                pick  = IDW'(sum);
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        valid_d = valid_q;
        id_d    = id_q;
        rr_d    = rr_q;
        case (fsm_q)
            StIdle: begin
                if (found) begin
                    id_d    = pick;
                    valid_d = 1'b1;
                    fsm_d   = StOffer;
                end
            end
            StOffer: begin
                if (evt_ready) begin
                    rr_d    = (id_q == IDW'(N_BTN - 1)) ? '0 : id_q + 1'b1;
                    valid_d = 1'b0;
                    fsm_d   = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= '0;
            s1_q    <= '0;
            state_q <= '0;
            dly_q   <= '0;
            cnt_q   <= '{default: '0};
            pend_q  <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            fsm_q   <= StIdle;
        end else begin
            s0_q    <= btn_raw;
            s1_q    <= s0_q;
            state_q <= state_d;
            dly_q   <= state_q;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            fsm_q   <= fsm_d;
        end
    end

    assign btn_state = state_q;
    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter (N_BTN=5, CNT_W=4, RPT_DLY=40, RPT_PER=20).
module tb_button_event_arbiter;
    localparam int N_BTN = 5;
    localparam int IDW   = 3;

    logic             clk = 1'b0;
    logic             rst, evt_ready, evt_valid, ovf;
    logic [N_BTN-1:0] btn_raw, btn_state;
    logic [IDW-1:0]   evt_id;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN(N_BTN), .IDW(IDW), .CNT_W(4), .RPT_DLY(24'd40), .RPT_PER(24'd20)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready), .ovf(ovf)
    );

    typedef struct { logic [IDW-1:0] id; int cyc; } obs_t;
    obs_t           obs_q[$];
    logic [IDW-1:0] exp_q[$];
    int             exp_off[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    // Handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) if (!rst && evt_valid && evt_ready) obs_q.push_back('{id: evt_id, cyc: cyc});

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int b, output int n);
        n = 0;
        while (!btn_state[b] && n < 60) begin tick(1); n++; end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        for (int k = 0; k < 200 && obs_q.size() < n; k++) tick(1);
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
        tick(3);
        checks++; if (btn_state !== '0) begin errors++; $display("FAIL reset_btn_state: got %0h expected 0", btn_state); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %0b expected 0", evt_valid); end
        checks++; if (evt_id !== '0) begin errors++; $display("FAIL reset_evt_id: got %0d expected 0", evt_id); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_clean_press();
        int c0, n;
        bit ok;
        obs_t o;
        evt_ready = 1'b1;
        c0 = cyc;
        btn_raw[2] = 1'b1;
        exp_q.push_back(3'd2);
        wait_rise(2, n);
        checks++; if (n != 18) begin errors++; $display("FAIL press_latency: got %0d expected 18", n); end
        tick(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL offer_early: got %0b expected 0", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL offer_valid: got %0b expected 1", evt_valid); end
        checks++; if (evt_id !== 3'd2) begin errors++; $display("FAIL offer_id: got %0d expected 2", evt_id); end
        tick(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %0b expected 0", evt_valid); end
        wait_obs(1, ok);
        tick(20);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL press_event_count: got %0d expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.id !== exp_q[0]) begin errors++; $display("FAIL press_id: got %0d expected %0d", o.id, exp_q[0]); end
            checks++; if (o.cyc != c0 + 20) begin errors++; $display("FAIL press_cycle: got %0d expected %0d", o.cyc, c0 + 20); end
        end
        obs_q.delete(); exp_q.delete();
        btn_raw[2] = 1'b0;
        tick(25);
        checks++; if (btn_state !== '0) begin errors++; $display("FAIL release_state: got %0h expected 0", btn_state); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL release_event: got %0d expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        int c0;
        bit ok;
        obs_t o;
        evt_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            btn_raw[0] = (k % 2 == 0);
            tick(5);
        end
        checks++; if (btn_state[0] !== 1'b0) begin errors++; $display("FAIL bounce_filtered: got %0b expected 0", btn_state[0]); end
        c0 = cyc;
        btn_raw[0] = 1'b1;
        exp_q.push_back(3'd0);
        wait_obs(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_timeout: got %0d events expected 1", obs_q.size()); end
        tick(20);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.id !== exp_q[0]) begin errors++; $display("FAIL bounce_id: got %0d expected %0d", o.id, exp_q[0]); end
            checks++; if (o.cyc != c0 + 20) begin errors++; $display("FAIL bounce_cycle: got %0d expected %0d", o.cyc, c0 + 20); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bounce_ovf: got %0b expected 0", ovf); end
        obs_q.delete(); exp_q.delete();
        btn_raw[0] = 1'b0;
        tick(25);
        obs_q.delete();
    endtask

    task automatic test_round_robin();
        bit ok;
        int c[3];
        int cnt;
        obs_t o;
        logic [IDW-1:0] e;
        evt_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                btn_raw = 5'b11010; exp_q.push_back(3'd1); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
            end else begin
                btn_raw = 5'b10010; exp_q.push_back(3'd1); exp_q.push_back(3'd4);
            end
            cnt = exp_q.size();
            wait_obs(cnt, ok);
            tick(20);
            checks++; if (obs_q.size() != cnt) begin errors++; $display("FAIL rr_count: got %0d expected %0d", obs_q.size(), cnt); end
            for (int k = 0; k < cnt && obs_q.size() > 0; k++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                c[k] = o.cyc;
                checks++; if (o.id !== e) begin errors++; $display("FAIL rr_order: got %0d expected %0d", o.id, e); end
                if (k > 0) begin
                    checks++; if (c[k] - c[k-1] != 2) begin errors++; $display("FAIL rr_spacing: got %0d expected 2", c[k] - c[k-1]); end
                end
            end
            obs_q.delete(); exp_q.delete();
            btn_raw = '0;
            tick(25);
            obs_q.delete();
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rr_ovf: got %0b expected 0", ovf); end
    endtask

    task automatic test_coalesce();
        int n;
        bit ok, stable;
        obs_t o;
        evt_ready = 1'b0;
        btn_raw[3] = 1'b1;
        wait_rise(3, n);
        tick(3);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd3) begin errors++; $display("FAIL hold_offer: got %0b/%0d expected 1/3", evt_valid, evt_id); end
        btn_raw[3] = 1'b0;
        tick(25);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b expected 0", ovf); end
        btn_raw[3] = 1'b1;
        wait_rise(3, n);
        tick(2);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", ovf); end
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (evt_valid !== 1'b1 || evt_id !== 3'd3) stable = 1'b0;
            tick(1);
        end
        checks++; if (!stable) begin errors++; $display("FAIL offer_stable: got %0b expected 1", stable); end
        exp_q.push_back(3'd3);
        evt_ready = 1'b1;
        wait_obs(1, ok);
        tick(20);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL coalesce_count: got %0d expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.id !== exp_q[0]) begin errors++; $display("FAIL coalesce_id: got %0d expected %0d", o.id, exp_q[0]); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", ovf); end
        obs_q.delete(); exp_q.delete();
        btn_raw[3] = 1'b0;
        tick(25);
        obs_q.delete();
    endtask

    task automatic test_reset_in_flight();
        int n, c0;
        bit ok;
        obs_t o;
        evt_ready = 1'b0;
        btn_raw[4] = 1'b1;
        wait_rise(4, n);
        tick(3);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 3'd4) begin errors++; $display("FAIL pre_reset_offer: got %0b/%0d expected 1/4", evt_valid, evt_id); end
        rst = 1'b1; btn_raw = '0;
        tick(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", evt_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", ovf); end
        checks++; if (btn_state !== '0) begin errors++; $display("FAIL rst_state: got %0h expected 0", btn_state); end
        tick(2);
        rst = 1'b0; evt_ready = 1'b1;
        tick(40);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rst_dropped: got %0d expected 0", obs_q.size()); end
        obs_q.delete();
        c0 = cyc;
        btn_raw[4] = 1'b1;
        exp_q.push_back(3'd4);
        wait_obs(1, ok);
        tick(10);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL post_rst_count: got %0d expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.id !== exp_q[0]) begin errors++; $display("FAIL post_rst_id: got %0d expected %0d", o.id, exp_q[0]); end
            checks++; if (o.cyc != c0 + 20) begin errors++; $display("FAIL post_rst_cycle: got %0d expected %0d", o.cyc, c0 + 20); end
        end
        obs_q.delete(); exp_q.delete();
        btn_raw[4] = 1'b0;
        tick(25);
        obs_q.delete();
    endtask

    task automatic test_auto_repeat();
        int n, cr, cnt;
        obs_t o;
        evt_ready = 1'b1;
        btn_raw[1] = 1'b1;
        wait_rise(1, n);
        cr = cyc;
        exp_q.push_back(3'd1); exp_off.push_back(2);
`ifdef AUTO_REPEAT_EN
        exp_q.push_back(3'd1); exp_off.push_back(41);
        exp_q.push_back(3'd1); exp_off.push_back(61);
        exp_q.push_back(3'd1); exp_off.push_back(81);
`endif
        tick(70);
        btn_raw[1] = 1'b0;
        tick(40);
        cnt = exp_q.size();
        checks++; if (obs_q.size() != cnt) begin errors++; $display("FAIL rpt_count: got %0d expected %0d", obs_q.size(), cnt); end
        for (int k = 0; k < cnt && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            checks++; if (o.id !== exp_q[k]) begin errors++; $display("FAIL rpt_id: got %0d expected %0d", o.id, exp_q[k]); end
            checks++; if (o.cyc - cr != exp_off[k]) begin errors++; $display("FAIL rpt_offset: got %0d expected %0d", o.cyc - cr, exp_off[k]); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rpt_ovf: got %0b expected 0", ovf); end
        obs_q.delete(); exp_q.delete(); exp_off.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_round_robin();
        test_coalesce();
        test_reset_in_flight();
        test_auto_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
